// File: rtl/rd_ptr_ctrl_p.sv
// Read-side pointer/flag controller for the async FIFO (rclk domain).
// Synchronises the write Gray pointer and produces read address, empty, almost-empty, fill count and underflow.
module rd_ptr_ctrl_p #(
    parameter int ADDR_W      = 3,
    parameter int SYNC_STAGES = 2,
    parameter int AE_THRESH   = 1
) (
    input  logic              rclk,
    input  logic              rrst,
    input  logic              ren,
    input  logic [ADDR_W:0]   wptr_gray,
    output logic [ADDR_W-1:0] raddr,
    output logic [ADDR_W:0]   rptr_gray,
    output logic              empty,
    output logic              almost_empty,
    output logic [ADDR_W:0]   rcount,
    output logic              underflow
);

    localparam int PW = ADDR_W + 1;
    localparam logic [PW-1:0] AE_LIM = PW'(AE_THRESH);

    logic [SYNC_STAGES-1:0][PW-1:0] wq;
    logic [PW-1:0] wq_gray;
    logic [PW-1:0] wq_bin;
    logic [PW-1:0] rbin;
    logic [PW-1:0] rbin_next;
    logic [PW-1:0] rgray_next;
    logic [PW-1:0] cnt_next;
    logic          rd_fire;

    // Plain flop chain: nothing may sit between the stages.
    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            wq <= '0;
        end else begin
            wq[0] <= wptr_gray;
            for (int i = 1; i < SYNC_STAGES; i++)
                wq[i] <= wq[i-1];
        end
    end

    assign wq_gray = wq[SYNC_STAGES-1];

    always_comb begin
        wq_bin = '0;
        for (int i = 0; i < PW; i++)
            wq_bin[i] = ^(wq_gray >> i);
    end

    assign rd_fire    = ren & ~empty;
    assign rbin_next  = rbin + PW'(rd_fire);
    assign rgray_next = rbin_next ^ (rbin_next >> 1);
    // Modular difference keeps a full FIFO at 2**ADDR_W rather than 0.
    assign cnt_next   = wq_bin - rbin_next;

    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            rbin         <= '0;
            rptr_gray    <= '0;
            empty        <= 1'b1;
            almost_empty <= 1'b1;
            rcount       <= '0;
            underflow    <= 1'b0;
        end else begin
            rbin         <= rbin_next;
            rptr_gray    <= rgray_next;
            empty        <= (rgray_next == wq_gray);
            almost_empty <= (cnt_next <= AE_LIM);
            rcount       <= cnt_next;
            underflow    <= ren & empty;
        end
    end

    assign raddr = rbin[ADDR_W-1:0];

endmodule
